// File: rtl/head_soccer_ball_physics.sv
// head_soccer_ball_physics: per-frame ball physics and goal/score engine.
// Each vsync falling edge runs one update WAIT->GRAV->MOVE->WALL->CHAR->COMMIT, or diverts to GOAL/FREEZE.
module head_soccer_ball_physics #(
    parameter int BALL_S        = 8,
    parameter int GROUND_Y      = 440,
    parameter int LEFT_WALL     = 8,
    parameter int RIGHT_WALL    = 631,
    parameter int GOAL_TOP      = 360,
    parameter int CHAR_W        = 40,
    parameter int CHAR_H        = 50,
    parameter int GRAVITY       = 1,
    parameter int MAX_VY        = 12,
    parameter int KICK_VX       = 6,
    parameter int KICK_VY       = -9,
    parameter int SERVE_X       = 320,
    parameter int SERVE_Y       = 100,
    parameter int FREEZE_FRAMES = 60
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic       vsync,
    input  logic [9:0] Char1X,
    input  logic [9:0] Char1Y,
    input  logic [9:0] Char2X,
    input  logic [9:0] Char2Y,
    input  logic       kick1,
    input  logic       kick2,
    output logic [9:0] BallX,
    output logic [9:0] BallY,
    output logic [9:0] BallS,
    output logic       goal1,
    output logic       goal2,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic       busy
);
    typedef enum logic [2:0] {WAIT, GRAV, MOVE, WALL, CHAR, COMMIT, GOAL, FREEZE} state_t;
    state_t state;
    logic vsync_d, scorer1, tick;
    logic signed [5:0] vx, vy, gvy, fvy, wvx, cvx, cvy, half, neg_abs;
    logic signed [10:0] nx, ny, fy, wx;
    logic [5:0] frz;
    logic lw, rw, top, g1, g2, hit1, hit2;
    int gv, xi, yi;

    assign BallS = 10'(BALL_S);
    assign tick  = vsync_d && !vsync;

    always_comb begin
        gv = int'(vy) + GRAVITY;
        gvy = gv > MAX_VY ? 6'(MAX_VY) : gv < -MAX_VY ? 6'(-MAX_VY) : 6'(gv);
        xi = int'(nx);
        yi = int'(ny);
        half = -(vy >>> 1);
        fy = ny;
        fvy = vy;
        if (yi + BALL_S >= GROUND_Y) begin
            fy = 11'(GROUND_Y - BALL_S);
            fvy = (int'(half) > -2 && int'(half) < 2) ? '0 : half;
        end else if (yi - BALL_S <= 0) begin
            fy = 11'(BALL_S);
            fvy = -vy;
        end
        // side checks see the floor-corrected y, so a rolling ball can score
        lw = xi - BALL_S <= LEFT_WALL;
        rw = xi + BALL_S >= RIGHT_WALL;
        top = int'(fy) - BALL_S >= GOAL_TOP;
        g2 = lw && top;
        g1 = rw && !lw && top;
        wx = top ? nx : lw ? 11'(LEFT_WALL + BALL_S) : rw ? 11'(RIGHT_WALL - BALL_S) : nx;
        wvx = (lw || rw) && !top ? -vx : vx;
        hit1 = xi - BALL_S < int'(Char1X) + CHAR_W && int'(Char1X) < xi + BALL_S &&
               yi - BALL_S < int'(Char1Y) + CHAR_H && int'(Char1Y) < yi + BALL_S;
        hit2 = xi - BALL_S < int'(Char2X) + CHAR_W && int'(Char2X) < xi + BALL_S &&
               yi - BALL_S < int'(Char2Y) + CHAR_H && int'(Char2Y) < yi + BALL_S;
        neg_abs = vy < 0 ? vy : -vy;
        cvx = hit1 && hit2 ? '0 : hit1 ? 6'(KICK_VX) : hit2 ? 6'(-KICK_VX) : vx;
        cvy = hit1 && hit2 ? 6'(KICK_VY) :
              hit1 ? (kick1 ? 6'(KICK_VY) : neg_abs) :
              hit2 ? (kick2 ? 6'(KICK_VY) : neg_abs) : vy;
    end

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            state   <= WAIT;
            vsync_d <= 1'b1;
            BallX   <= 10'(SERVE_X);
            BallY   <= 10'(SERVE_Y);
            vx      <= '0;
            vy      <= '0;
            nx      <= '0;
            ny      <= '0;
            score1  <= '0;
            score2  <= '0;
            goal1   <= 1'b0;
            goal2   <= 1'b0;
            busy    <= 1'b0;
            frz     <= '0;
            scorer1 <= 1'b0;
        end else begin
            vsync_d <= vsync;
            goal1   <= 1'b0;
            goal2   <= 1'b0;
            case (state)
                WAIT: if (tick) begin
                    state <= GRAV;
                    busy  <= 1'b1;
                end
                GRAV: begin
                    vy    <= gvy;
                    state <= MOVE;
                end
                MOVE: begin
                    nx    <= 11'(int'(BallX) + int'(vx));
                    ny    <= 11'(int'(BallY) + int'(vy));
                    state <= WALL;
                end
                WALL: begin
                    nx      <= wx;
                    ny      <= fy;
                    vx      <= wvx;
                    vy      <= fvy;
                    scorer1 <= g1;
                    state   <= g1 || g2 ? GOAL : CHAR;
                end
                CHAR: begin
                    vx    <= cvx;
                    vy    <= cvy;
                    state <= COMMIT;
                end
                COMMIT: begin
                    BallX <= nx[9:0];
                    BallY <= ny[9:0];
                    busy  <= 1'b0;
                    state <= WAIT;
                end
                GOAL: begin
                    goal1  <= scorer1;
                    goal2  <= !scorer1;
                    score1 <= score1 + 4'(scorer1 && score1 != 4'd9);
                    score2 <= score2 + 4'(!scorer1 && score2 != 4'd9);
                    frz    <= 6'(FREEZE_FRAMES);
                    state  <= FREEZE;
                end
                FREEZE: if (tick) begin
                    frz <= frz - 6'd1;
                    if (frz <= 6'd1) begin
                        BallX <= 10'(SERVE_X);
                        BallY <= 10'(SERVE_Y);
                        vx    <= '0;
                        vy    <= '0;
                        busy  <= 1'b0;
                        state <= WAIT;
                    end
                end
                default: state <= WAIT;
            endcase
        end
    end
endmodule

// File: tb/tb_head_soccer_ball_physics.sv
// tb_head_soccer_ball_physics: directed frames against a behavioural ball model via a scoreboard queue.
module tb_head_soccer_ball_physics;
    logic vga_clk = 1'b0, reset_n = 1'b0, vsync = 1'b1;
    logic [9:0] c1x = 10'd0, c1y = 10'd0, c2x = 10'd600, c2y = 10'd0;
    logic kick1 = 1'b0, kick2 = 1'b0;
    logic [9:0] BallX, BallY, BallS;
    logic goal1, goal2, busy;
    logic [3:0] score1, score2;

    head_soccer_ball_physics dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .vsync(vsync),
        .Char1X(c1x), .Char1Y(c1y), .Char2X(c2x), .Char2Y(c2y),
        .kick1(kick1), .kick2(kick2),
        .BallX(BallX), .BallY(BallY), .BallS(BallS),
        .goal1(goal1), .goal2(goal2), .score1(score1), .score2(score2), .busy(busy)
    );

    always #5 vga_clk = ~vga_clk;

    typedef struct {int x; int y; int s1; int s2; int g1; int g2; int busy;} sb_t;
    sb_t q[$];
    int total = 0, bad = 0;
    int g1c = 0, g2c = 0;
    int m_x, m_y, m_vx, m_vy, m_s1, m_s2, m_frz, m_g1, m_g2;

    always @(negedge vga_clk) begin
        if (goal1) g1c = g1c + 1;
        if (goal2) g2c = g2c + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_x = 320; m_y = 100; m_vx = 0; m_vy = 0; m_s1 = 0; m_s2 = 0; m_frz = 0;
    endtask

    task automatic model_tick();
        int nx, ny, h, a1, b1, a2, b2;
        bit lw, rw, top, h1, h2;
        m_g1 = 0;
        m_g2 = 0;
        if (m_frz > 0) begin
            m_frz--;
            if (m_frz == 0) begin
                m_x = 320; m_y = 100; m_vx = 0; m_vy = 0;
            end
            return;
        end
        m_vy = (m_vy + 1 > 12) ? 12 : (m_vy + 1 < -12) ? -12 : m_vy + 1;
        nx = m_x + m_vx;
        ny = m_y + m_vy;
        if (ny + 8 >= 440) begin
            ny = 432;
            h = -(m_vy >>> 1);
            m_vy = (h > -2 && h < 2) ? 0 : h;
        end else if (ny - 8 <= 0) begin
            ny = 8;
            m_vy = -m_vy;
        end
        lw = nx - 8 <= 8;
        rw = nx + 8 >= 631;
        top = ny - 8 >= 360;
        if ((lw || rw) && top) begin
            if (lw) begin
                m_g2 = 1;
                m_s2 = (m_s2 == 9) ? 9 : m_s2 + 1;
            end else begin
                m_g1 = 1;
                m_s1 = (m_s1 == 9) ? 9 : m_s1 + 1;
            end
            m_frz = 60;
            return;
        end
        if (lw) begin
            nx = 16; m_vx = -m_vx;
        end else if (rw) begin
            nx = 623; m_vx = -m_vx;
        end
        a1 = int'(c1x); b1 = int'(c1y); a2 = int'(c2x); b2 = int'(c2y);
        h1 = nx - 8 < a1 + 40 && a1 < nx + 8 && ny - 8 < b1 + 50 && b1 < ny + 8;
        h2 = nx - 8 < a2 + 40 && a2 < nx + 8 && ny - 8 < b2 + 50 && b2 < ny + 8;
        if (h1 && h2) begin
            m_vx = 0; m_vy = -9;
        end else if (h1) begin
            m_vx = 6; m_vy = kick1 ? -9 : (m_vy < 0 ? m_vy : -m_vy);
        end else if (h2) begin
            m_vx = -6; m_vy = kick2 ? -9 : (m_vy < 0 ? m_vy : -m_vy);
        end
        m_x = nx;
        m_y = ny;
    endtask

    task automatic push_expected();
        sb_t e;
        model_tick();
        e = '{m_x, m_y, m_s1, m_s2, m_g1, m_g2, int'(m_frz > 0)};
        q.push_back(e);
    endtask

    task automatic compare(input string tag, input int b1, input int b2);
        sb_t e;
        e = q.pop_front();
        check({tag, ".x"}, BallX, e.x);
        check({tag, ".y"}, BallY, e.y);
        check({tag, ".s1"}, score1, e.s1);
        check({tag, ".s2"}, score2, e.s2);
        check({tag, ".g1"}, g1c - b1, e.g1);
        check({tag, ".g2"}, g2c - b2, e.g2);
        check({tag, ".busy"}, busy, e.busy);
    endtask

    task automatic frame(input string tag);
        int b1, b2;
        b1 = g1c;
        b2 = g2c;
        push_expected();
        @(negedge vga_clk) vsync = 1'b0;
        repeat (8) @(negedge vga_clk);
        vsync = 1'b1;
        @(negedge vga_clk);
        compare(tag, b1, b2);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        vsync = 1'b1;
        repeat (3) @(negedge vga_clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int b1, b2;
        model_reset();
        // T1 reset
        repeat (3) @(negedge vga_clk);
        check("t1.x", BallX, 320);
        check("t1.y", BallY, 100);
        check("t1.s", BallS, 8);
        check("t1.s1", score1, 0);
        check("t1.s2", score2, 0);
        check("t1.busy", busy, 0);
        check("t1.goal", {goal1, goal2}, 0);
        reset_n = 1'b1;
        @(negedge vga_clk);
        // T2 free fall
        frame("t2.f1");
        check("t2.y1", BallY, 101);
        frame("t2.f2");
        check("t2.y2", BallY, 103);
        frame("t2.f3");
        check("t2.y3", BallY, 106);
        check("t2.x", BallX, 320);
        // T3 floor bounce and settle
        for (int i = 0; i < 60 && m_y != 432; i++) frame("t3.fall");
        check("t3.land", BallY, 432);
        frame("t3.bounce");
        check("t3.rise", BallY < 10'd432, 1);
        for (int i = 0; i < 30; i++) frame("t3.settle");
        for (int i = 0; i < 3; i++) begin
            frame("t3.rest");
            check("t3.hold", BallY, 432);
        end
        check("t3.x", BallX, 320);
        // T4 kick by char1
        c1x = 10'd300; c1y = 10'd400; kick1 = 1'b1;
        frame("t4.kick");
        c1x = 10'd0; c1y = 10'd0; kick1 = 1'b0;
        frame("t4.fly");
        check("t4.x", BallX, 326);
        check("t4.y", BallY, 424);
        // T5 goal on the left wall
        do_reset();
        for (int i = 0; i < 80 && !(m_y == 432 && m_vy == 0); i++) frame("t5.fall");
        c2x = 10'd300; c2y = 10'd400;
        frame("t5.push");
        c2x = 10'd600; c2y = 10'd0;
        for (int i = 0; i < 80 && m_frz == 0; i++) frame("t5.slide");
        check("t5.s2", score2, 1);
        check("t5.s1", score1, 0);
        check("t5.x", BallX, 20);
        check("t5.y", BallY, 432);
        for (int i = 0; i < 59; i++) frame("t5.hold");
        check("t5.held", BallX, 20);
        check("t5.busy", busy, 1);
        frame("t5.serve");
        check("t5.sx", BallX, 320);
        check("t5.sy", BallY, 100);
        frame("t6.pre1");
        frame("t6.pre2");
        check("t6.pre", BallY, 103);
        // T6 reset while in MOVE
        @(negedge vga_clk) vsync = 1'b0;
        repeat (2) @(negedge vga_clk);
        reset_n = 1'b0;
        vsync = 1'b1;
        @(negedge vga_clk);
        check("t6.rx", BallX, 320);
        check("t6.ry", BallY, 100);
        check("t6.rs2", score2, 0);
        check("t6.rbusy", busy, 0);
        reset_n = 1'b1;
        model_reset();
        // vsync glitch inside the update must not start a second one
        b1 = g1c;
        b2 = g2c;
        push_expected();
        @(negedge vga_clk) vsync = 1'b0;
        @(negedge vga_clk) vsync = 1'b1;
        @(negedge vga_clk) vsync = 1'b0;
        repeat (6) @(negedge vga_clk);
        vsync = 1'b1;
        @(negedge vga_clk);
        compare("t6.glitch", b1, b2);
        check("t6.gy", BallY, 101);
        frame("t6.next");
        check("t6.ny", BallY, 103);
        check("t6.q", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
